// File: rtl/prog_loader.sv
// Program loader: assembles a big-endian byte stream into 32-bit words,
// writes them to instruction memory from address 0 upward, then releases
// the processor from hold.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | reset state, waiting for start
// RECV  | collecting the four bytes of the current word
// WRITE | single-cycle instruction-memory write of the assembled word
// DONE  | image loaded, processor running; start reloads from address 0
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_s,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              cpu_run
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Largest loadable image; word_count is wide enough to hold it exactly.
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;

  // State, word counter, byte counter and word buffer registers.
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      index_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (word_count == '0) begin
            state_d = DONE;
          end else begin
            state_d    = RECV;
            count_d    = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
            index_d    = '0;
            byte_cnt_d = '0;
            word_d     = '0;
          end
        end
      end
      RECV: begin
        if (byte_valid) begin
          // Shifting left leaves the first byte in [31:24] after four bytes.
          word_d     = {word_q[23:0], byte_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // count_q >= 1 here, so count_q-1 always fits the index width.
        if ({1'b0, index_q} == (count_q - (ADDR_W+1)'(1))) begin
          state_d = DONE;
        end else begin
          index_d = index_q + ADDR_W'(1);
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded purely from registered state and datapath.
  always_comb begin
    byte_ready = (state_q == RECV);
    imem_we    = (state_q == WRITE);
    busy       = (state_q == RECV) || (state_q == WRITE);
    cpu_run    = (state_q == DONE);
    imem_addr  = '0;
    imem_wdata = '0;
    if (state_q == WRITE) begin
      imem_addr[ADDR_W+1:0] = {index_q, 2'b00};
      imem_wdata            = word_q;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader with a queue-based scoreboard: each load
// pushes the expected (address, word) writes, and a negedge monitor pops and
// compares whenever the loader strobes instruction memory.
module tb_prog_loader;

  localparam int AW = 4;  // 16-word image keeps the clamp case short

  logic          clk_s;
  logic          rst_n;
  logic          start;
  logic [AW:0]   word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          cpu_run;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  src[$];
  int          total;
  int          bad;
  bit          mon_en;

  prog_loader #(.ADDR_W(AW)) dut (
    .clk_s      (clk_s),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .cpu_run    (cpu_run)
  );

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every write, checks quiet outputs otherwise.
  initial begin
    exp_t e;
    bit   last_we;
    last_we = 1'b0;
    forever begin
      @(negedge clk_s);
      if (mon_en) begin
        if (imem_we === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_write", imem_addr, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("write_addr", imem_addr, e.a);
            chk("write_data", imem_wdata, e.d);
          end
          chk("write_flags", {29'd0, busy, byte_ready, cpu_run}, 32'd4);
        end else begin
          chk("idle_addr_data", imem_addr | imem_wdata, 32'd0);
          if (last_we && sb.size() == 0) chk("run_after_last", {31'd0, cpu_run}, 32'd1);
        end
        last_we = (imem_we === 1'b1);
      end
    end
  end

  task automatic fill_random(input int n_words);
    for (int i = 0; i < 4 * n_words; i++) src.push_back(8'($urandom));
  endtask

  // Run one load: push expectations from the byte image, pulse start, feed
  // bytes (mode 0 continuous, 1 three-cycle gaps, 2 random valid), optionally
  // pulse start mid-load, then wait for cpu_run.
  task automatic do_load(input int wc, input int n_eff, input int mode, input int inject_at);
    int  sent, gap, cyc;
    bit  v, acc, injected;
    for (int i = 0; i < n_eff; i++)
      sb.push_back('{32'(i * 4), {src[4*i], src[4*i+1], src[4*i+2], src[4*i+3]}});
    @(posedge clk_s); #1;
    start = 1'b1;
    word_count = (AW+1)'(wc);
    @(posedge clk_s); #1;
    start = 1'b0;
    word_count = (AW+1)'($urandom);
    chk("start_accept", {30'd0, busy, cpu_run}, 32'd2);
    sent = 0; gap = 0; cyc = 0; injected = 1'b0;
    while (src.size() > 0 && cyc < 3000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (gap == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 1 && !v && (sent % 4) != 0) chk("gap_ready", {31'd0, byte_ready}, 32'd1);
      byte_valid = v;
      byte_data  = v ? src[0] : 8'($urandom);
      if (!injected && inject_at >= 0 && sent == inject_at) begin
        start = 1'b1;
        word_count = (AW+1)'(1);
        injected = 1'b1;
      end
      acc = v && byte_ready;
      @(posedge clk_s); #1;
      start = 1'b0;
      if (acc) begin
        void'(src.pop_front());
        sent++;
        gap = (mode == 1) ? 3 : 0;
      end else if (gap > 0) begin
        gap--;
      end
      cyc++;
    end
    byte_valid = 1'b0;
    if (src.size() != 0) chk("feed_timeout", src.size(), 32'd0);
    cyc = 0;
    while (cpu_run !== 1'b1 && cyc < 50) begin
      @(posedge clk_s); #1;
      cyc++;
    end
    chk("load_done", {30'd0, busy, cpu_run}, 32'd1);
    @(negedge clk_s); #1;
    chk("sb_drained", sb.size(), 32'd0);
    src.delete();
  endtask

  initial begin
    int n;
    total = 0; bad = 0; mon_en = 1'b0;
    rst_n = 1'b0; start = 1'b0; word_count = '0;
    byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(posedge clk_s); #1;
    chk("rst_flags", {28'd0, byte_ready, imem_we, busy, cpu_run}, 32'd0);
    chk("rst_addr_data", imem_addr | imem_wdata, 32'd0);
    @(negedge clk_s); rst_n = 1'b1; mon_en = 1'b1;
    @(posedge clk_s); #1;
    chk("idle_after_rel", {29'd0, byte_ready, busy, cpu_run}, 32'd0);

    // Directed two-word image, continuous bytes.
    src = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(2, 2, 0, -1);

    // Same image with three idle cycles between bytes.
    src = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(2, 2, 1, -1);

    // Empty image: straight to run, no write.
    @(posedge clk_s); #1;
    start = 1'b1; word_count = '0;
    @(posedge clk_s); #1;
    start = 1'b0;
    chk("empty_run", {30'd0, busy, cpu_run}, 32'd1);
    repeat (3) @(posedge clk_s); #1;
    chk("empty_hold", {29'd0, imem_we, busy, cpu_run}, 32'd1);

    // Abort: reset mid-cycle after two accepted bytes.
    @(posedge clk_s); #1;
    start = 1'b1; word_count = (AW+1)'(1);
    @(posedge clk_s); #1;
    start = 1'b0; byte_valid = 1'b1; byte_data = 8'h11;
    @(posedge clk_s); #1;
    byte_data = 8'h22;
    @(posedge clk_s); #1;
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_flags", {28'd0, byte_ready, imem_we, busy, cpu_run}, 32'd0);
    chk("async_rst_data", imem_addr | imem_wdata, 32'd0);
    repeat (2) @(posedge clk_s);
    @(negedge clk_s); rst_n = 1'b1;
    @(posedge clk_s); #1;
    chk("idle_after_abort", {29'd0, byte_ready, busy, cpu_run}, 32'd0);
    src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(1, 1, 0, -1);

    // Start during RECV ignored, then restart from DONE.
    fill_random(3);
    do_load(3, 3, 2, 2);
    fill_random(2);
    do_load(2, 2, 2, 6);

    // Random images.
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 6);
      fill_random(n);
      do_load(n, n, (k == 0) ? 0 : 2, -1);
    end

    // Full-size image and oversize count clamped to the full size.
    fill_random(16);
    do_load(16, 16, 2, -1);
    fill_random(16);
    do_load(20, 16, 0, -1);

    repeat (5) @(posedge clk_s); #1;
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
